// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the two-master on-chip RAM arbiter:
// default bus widths, the master index type and the round-robin reset state.
package onchip_mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;   // 1024-word RAM
    localparam int DEF_DATA_W = 32;

    // Index of one of the two masters
    typedef logic mst_idx_t;

    // `last` comes out of reset pointing at master 1 so master 0 wins the first tie
    localparam mst_idx_t LAST_RST = 1'b1;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master port as seen by the arbiter: request side driven by the
// master, waitrequest/read response driven back by the arbiter.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = onchip_mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = onchip_mem_arb_pkg::DEF_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational; `last` remembers the
// most recent winner so that on a tie the other master is served next.
module rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       freeze,
    output logic [1:0] grant
);

    mst_idx_t last_q;
    mst_idx_t last_d;

    // Pick the winner for this cycle and the new `last` if a grant is issued
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (!freeze) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_q == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        if (grant != 2'b00) begin
            last_d = grant[1];
        end
    end

    // Winner history register; holds whenever no grant is issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM masters. The RAM
// output is unregistered behind a registered address, so read data is valid
// exactly one cycle after the grant edge and is broadcast to both masters,
// qualified by a per-master readdatavalid.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  freeze,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] wait_vec;
    logic [1:0] rd_pend_q;
    logic [1:0] rd_pend_d;

    // A write and read together on one master is treated as a write
    assign wr_req = {m1.write, m0.write};
    assign rd_req = {m1.read, m0.read} & ~wr_req;

    // Requests are held off during reset so nothing reaches the RAM
    assign req = (wr_req | rd_req) & {2{reset_n}};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .freeze  (freeze),
        .grant   (grant)
    );

    // Per-master stall: the loser (or everyone under freeze/reset) waits
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wait
            assign wait_vec[gi] = ~reset_n | (req[gi] & ~grant[gi]);
        end
    endgenerate

    // Route the granted master's request onto the RAM port
    always_comb begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        mem_chipselect = |grant;
        mem_write      = 1'b0;
        if (grant[1]) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            mem_write      = wr_req[1];
        end else if (grant[0]) begin
            mem_write      = wr_req[0];
        end
    end

    // Remember which master, if any, gets the RAM output next cycle
    always_comb begin
        rd_pend_d = grant & rd_req;
    end

    // Read-in-flight register; reset drops any pending response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 2'b00;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    // The RAM never stalls once out of reset
    assign mem_clken = reset_n;

    assign m0.waitrequest   = wait_vec[0];
    assign m1.waitrequest   = wait_vec[1];
    assign m0.readdatavalid = rd_pend_q[0];
    assign m1.readdatavalid = rd_pend_q[1];
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1024x32 RAM
// (registered address, unregistered output) and a read-response scoreboard.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        freeze = 1'b0;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    onchip_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0_if ();
    onchip_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1_if ();

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .freeze         (freeze),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: address registered on enabled edges, output combinational
    logic [31:0] ram [0:1023];
    logic [9:0]  ram_addr_q = '0;
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          m;
        logic [31:0] d;
        int          cyc;
    } exp_t;
    exp_t sb [$];
    exp_t mon_e;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: a scheduled read must show up on exactly its cycle
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk(32'(m0_if.readdatavalid), 32'(mon_e.m == 0), "rdv0");
            chk(32'(m1_if.readdatavalid), 32'(mon_e.m == 1), "rdv1");
            chk((mon_e.m == 0) ? m0_if.readdata : m1_if.readdata, mon_e.d, "rdata");
            $display("[%0t] read response m%0d data=%h", $time, mon_e.m, mon_e.d);
        end else begin
            chk(32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'd0, "no_rdv");
        end
    end

    task automatic drive(input int m, input logic rd, input logic wr,
                         input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    // One bus cycle: check request-side outputs mid-cycle, schedule an
    // expected read response, then advance to just after the next edge
    task automatic tick(input logic ew0, input logic ew1, input logic ecs, input logic ewe,
                        input logic [9:0] ea, input int rd_m, input logic [31:0] rd_d,
                        input string tag);
        @(negedge clk);
        chk(32'(m0_if.waitrequest), 32'(ew0), {tag, ":wait0"});
        chk(32'(m1_if.waitrequest), 32'(ew1), {tag, ":wait1"});
        chk(32'(mem_chipselect), 32'(ecs), {tag, ":cs"});
        chk(32'(mem_write), 32'(ewe), {tag, ":we"});
        chk(32'(mem_clken), 32'(reset_n), {tag, ":clken"});
        if (ecs) chk(32'(mem_address), 32'(ea), {tag, ":addr"});
        if (rd_m >= 0) sb.push_back('{m: rd_m, d: rd_d, cyc: cyc + 1});
        $display("[%0t] %s wait=%b%b cs=%b we=%b addr=%0d", $time, tag,
                 m1_if.waitrequest, m0_if.waitrequest, mem_chipselect, mem_write, mem_address);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 1'b1, 1'b0, 10'd3, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 10'd4, 4'hF, 32'h0);
        #2 reset_n = 1'b0;

        // Reset with both masters reading
        tick(1, 1, 0, 0, 0, -1, 0, "rst_a");
        tick(1, 1, 0, 0, 0, -1, 0, "rst_b");
        reset_n = 1'b1;

        // First tie after reset goes to m0, then alternates
        tick(0, 1, 1, 0, 10'd3, 0, 32'h0, "tie0");
        tick(1, 0, 1, 0, 10'd4, 1, 32'h0, "tie1");

        // Single master write then read back
        drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        drive(0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
        tick(0, 0, 1, 1, 10'd5, -1, 0, "wr5");
        drive(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        tick(0, 0, 1, 0, 10'd5, 0, 32'hDEADBEEF, "rd5");
        drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        tick(0, 0, 0, 0, 0, -1, 0, "idle");

        // Preload words 1 and 2 with contending writes (m0 won last -> m1 first)
        drive(0, 1'b0, 1'b1, 10'd1, 4'hF, 32'h11);
        drive(1, 1'b0, 1'b1, 10'd2, 4'hF, 32'h22);
        tick(1, 0, 1, 1, 10'd2, -1, 0, "pre2");
        drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        tick(0, 0, 1, 1, 10'd1, -1, 0, "pre1");

        // Sustained read contention: strict alternation
        drive(0, 1'b1, 1'b0, 10'd1, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) tick(1, 0, 1, 0, 10'd2, 1, 32'h22, "cont_m1");
            else            tick(0, 1, 1, 0, 10'd1, 0, 32'h11, "cont_m0");
        end

        // Byte lanes: clear word 7, partial write, read back consecutively
        drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        drive(0, 1'b0, 1'b1, 10'd7, 4'hF, 32'h0);
        tick(0, 0, 1, 1, 10'd7, -1, 0, "clr7");
        drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b1, 10'd7, 4'h6, 32'hAABBCCDD);
        tick(0, 0, 1, 1, 10'd7, -1, 0, "be7");
        drive(1, 1'b1, 1'b0, 10'd7, 4'hF, 32'h0);
        tick(0, 0, 1, 0, 10'd7, 1, 32'h00BBCC00, "rd7");

        // Freeze with a read already granted
        drive(0, 1'b1, 1'b0, 10'd1, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0);
        tick(0, 1, 1, 0, 10'd1, 0, 32'h11, "frz_pre");
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, -1, 0, "frz");
        freeze = 1'b0;
        tick(1, 0, 1, 0, 10'd2, 1, 32'h22, "frz_m1");
        tick(0, 1, 1, 0, 10'd1, 0, 32'h11, "frz_m0");

        // Reset in the cycle after a read grant drops the response
        drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        tick(0, 0, 1, 0, 10'd1, -1, 0, "mr_rd");
        reset_n = 1'b0;
        tick(1, 1, 0, 0, 0, -1, 0, "mr_rst");
        reset_n = 1'b1;
        drive(1, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0);
        tick(0, 1, 1, 0, 10'd1, 0, 32'h11, "post_m0");
        tick(1, 0, 1, 0, 10'd2, 1, 32'h22, "post_m1");
        drive(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        tick(0, 0, 0, 0, 0, -1, 0, "drain_a");
        tick(0, 0, 0, 0, 0, -1, 0, "drain_b");

        chk(32'(sb.size()), 32'd0, "sb_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
